// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Types and constants for the memory-access pipeline stage:
//               memory operation codes, FSM state encoding, funct3 access
//               codes and the latched stage record.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

  localparam int XLEN_P = 32;

  typedef enum logic [1:0] {
    MNONE  = 2'd0,
    MLOAD  = 2'd1,
    MSTORE = 2'd2
  } mem_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_REQ  = ST_REQ,
    S_WAIT = ST_WAIT
  } state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // Fields held while a memory transaction is outstanding. The destination
  // register id is kept outside because its width is a stage parameter.
  typedef struct packed {
    logic [XLEN_P-1:0] pc;
    logic [XLEN_P-1:0] alu_result;
    logic [XLEN_P-1:0] store_data;
    logic [2:0]        funct3;
    mem_op_e           mem_op;
    logic [2:0]        wb_op;
  } stage_rec_t;

endpackage
`default_nettype wire

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Write-back select encodings shared by the execute, memory and
//               write-back stages. WNONE suppresses the register-file write.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  typedef enum logic [2:0] {
    WNONE = 3'd0,
    WALU  = 3'd1,
    WMEM  = 3'd2,
    WPC4  = 3'd3,
    WIMM  = 3'd4
  } wb_op_e;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Combinational byte-lane helper. Produces store byte enables,
//               lane-replicated store data, the right-aligned load word and
//               the access legality flag.
// Ports       : addr_lo_i   - address bits [1:0]
//               funct3_i    - access size / signedness
//               is_load_i   - access is a load
//               is_store_i  - access is a store
//               wdata_i     - raw store data (rs2)
//               rdata_i     - raw read word from memory
//               be_o        - byte enables
//               wdata_o     - replicated store data
//               rdata_o     - read word shifted down to byte lane 0
//               illegal_o   - access must fault
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]        addr_lo_i,
  input  logic [2:0]        funct3_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [XLEN_P-1:0] wdata_i,
  input  logic [XLEN_P-1:0] rdata_i,
  output logic [3:0]        be_o,
  output logic [XLEN_P-1:0] wdata_o,
  output logic [XLEN_P-1:0] rdata_o,
  output logic              illegal_o
);

  logic w_bad_f3;
  logic w_unsigned_store;
  logic w_mis_half;
  logic w_mis_word;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    // funct3[1:0] selects the size; bit 2 only carries signedness.
    unique case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

  assign w_bad_f3         = (funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7);
  assign w_unsigned_store = is_store_i && ((funct3_i == F3_LBU) || (funct3_i == F3_LHU));
  assign w_mis_half       = ((funct3_i == F3_LH) || (funct3_i == F3_LHU)) && addr_lo_i[0];
  assign w_mis_word       = (funct3_i == F3_LW) && (addr_lo_i != 2'b00);

  assign illegal_o = (is_load_i || is_store_i) &&
                     (w_bad_f3 || w_unsigned_store || w_mis_half || w_mis_word);

  assign rdata_o = rdata_i >> {addr_lo_i, 3'b000};

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline stage between execute and write-back. Issues loads
//               and stores over a valid/ready request port, waits for read
//               data, and presents a registered record to write-back. The
//               upstream stage is stalled while a transaction is outstanding.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               ex_*                  - execute record in, ex_ready_out stall
//               mem_*_out / mem_*_in  - data memory request / response
//               wb_*_out              - registered write-back record
//               mem_fault_out         - fault pulse aligned with wb_valid_out
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import mem_access_pkg::*;
  import wb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int RD_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid_in,
  output logic                ex_ready_out,
  input  logic [XLEN-1:0]     ex_pc_in,
  input  logic [XLEN-1:0]     ex_alu_result_in,
  input  logic [XLEN-1:0]     ex_store_data_in,
  input  logic [2:0]          ex_funct3_in,
  input  logic [1:0]          ex_mem_op_in,
  input  logic [2:0]          ex_wb_op_in,
  input  logic [RD_WIDTH-1:0] ex_rd_in,
  output logic                mem_req_out,
  output logic                mem_we_out,
  output logic [XLEN-1:0]     mem_addr_out,
  output logic [XLEN-1:0]     mem_wdata_out,
  output logic [3:0]          mem_be_out,
  input  logic                mem_ready_in,
  input  logic                mem_rvalid_in,
  input  logic [XLEN-1:0]     mem_rdata_in,
  output logic                wb_valid_out,
  output logic [XLEN-1:0]     wb_pc_out,
  output logic [XLEN-1:0]     wb_alu_result_out,
  output logic [2:0]          wb_funct3_out,
  output logic [2:0]          wb_wb_op_out,
  output logic [RD_WIDTH-1:0] wb_rd_out,
  output logic [XLEN-1:0]     wb_mem_data_out,
  output logic                mem_fault_out
);

  // One spare count above the limit: a REQ handshake on the limit cycle
  // moves to WAIT with the counter already at the limit.
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0]  TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  stage_rec_t          rec_q, rec_d;
  logic [RD_WIDTH-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                wb_valid_q, wb_valid_d;
  logic                fault_q, fault_d;
  logic [XLEN-1:0]     wb_pc_q, wb_pc_d;
  logic [XLEN-1:0]     wb_alu_q, wb_alu_d;
  logic [2:0]          wb_funct3_q, wb_funct3_d;
  logic [2:0]          wb_op_q, wb_op_d;
  logic [RD_WIDTH-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]     wb_mem_data_q, wb_mem_data_d;

  logic                w_idle;
  logic                w_ex_is_ld;
  logic                w_ex_is_st;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_timeout;
  logic [1:0]          w_al_addr_lo;
  logic [2:0]          w_al_funct3;
  logic                w_al_is_ld;
  logic                w_al_is_st;
  logic [XLEN-1:0]     w_al_wdata;
  logic [3:0]          w_be;
  logic [XLEN-1:0]     w_wdata;
  logic [XLEN-1:0]     w_load_data;
  logic                w_illegal;

  logic                emit_ex;
  logic                emit_rec;
  logic                emit_fault;
  logic [XLEN-1:0]     emit_data;

  assign w_idle     = (state_q == S_IDLE);
  assign w_ex_is_ld = (ex_mem_op_in == MLOAD);
  assign w_ex_is_st = (ex_mem_op_in == MSTORE);
  assign w_cnt_inc  = cnt_q + 1'b1;
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_inc >= TO_LIMIT);

  // The lane helper checks the incoming record while idle and works from
  // the latched record once a transaction is in flight.
  assign w_al_addr_lo = w_idle ? ex_alu_result_in[1:0] : rec_q.alu_result[1:0];
  assign w_al_funct3  = w_idle ? ex_funct3_in          : rec_q.funct3;
  assign w_al_is_ld   = w_idle ? w_ex_is_ld            : (rec_q.mem_op == MLOAD);
  assign w_al_is_st   = w_idle ? w_ex_is_st            : (rec_q.mem_op == MSTORE);
  assign w_al_wdata   = w_idle ? ex_store_data_in      : rec_q.store_data;

  mem_lane_align u_lane (
    .addr_lo_i  (w_al_addr_lo),
    .funct3_i   (w_al_funct3),
    .is_load_i  (w_al_is_ld),
    .is_store_i (w_al_is_st),
    .wdata_i    (w_al_wdata),
    .rdata_i    (mem_rdata_in),
    .be_o       (w_be),
    .wdata_o    (w_wdata),
    .rdata_o    (w_load_data),
    .illegal_o  (w_illegal)
  );

  always_comb begin
    state_d    = state_q;
    rec_d      = rec_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    emit_ex    = 1'b0;
    emit_rec   = 1'b0;
    emit_fault = 1'b0;
    emit_data  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (ex_valid_in) begin
          if ((w_ex_is_ld || w_ex_is_st) && !w_illegal) begin
            rec_d.pc         = ex_pc_in;
            rec_d.alu_result = ex_alu_result_in;
            rec_d.store_data = ex_store_data_in;
            rec_d.funct3     = ex_funct3_in;
            rec_d.mem_op     = mem_op_e'(ex_mem_op_in);
            rec_d.wb_op      = ex_wb_op_in;
            rd_d             = ex_rd_in;
            cnt_d            = '0;
            state_d          = S_REQ;
          end else begin
            emit_ex    = 1'b1;
            emit_fault = w_illegal;
          end
        end
      end
      S_REQ: begin
        if (mem_ready_in) begin
          if (rec_q.mem_op == MSTORE) begin
            emit_rec = 1'b1;
            state_d  = S_IDLE;
          end else begin
            cnt_d   = w_cnt_inc;
            state_d = S_WAIT;
          end
        end else if (w_timeout) begin
          emit_rec   = 1'b1;
          emit_fault = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_in) begin
          emit_rec  = 1'b1;
          emit_data = w_load_data;
          state_d   = S_IDLE;
        end else if (w_timeout) begin
          emit_rec   = 1'b1;
          emit_fault = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_valid_d    = emit_ex || emit_rec;
    fault_d       = emit_fault;
    wb_pc_d       = wb_pc_q;
    wb_alu_d      = wb_alu_q;
    wb_funct3_d   = wb_funct3_q;
    wb_op_d       = wb_op_q;
    wb_rd_d       = wb_rd_q;
    wb_mem_data_d = wb_mem_data_q;
    if (emit_ex) begin
      wb_pc_d       = ex_pc_in;
      wb_alu_d      = ex_alu_result_in;
      wb_funct3_d   = ex_funct3_in;
      wb_op_d       = emit_fault ? WNONE : ex_wb_op_in;
      wb_rd_d       = ex_rd_in;
      wb_mem_data_d = '0;
    end else if (emit_rec) begin
      wb_pc_d       = rec_q.pc;
      wb_alu_d      = rec_q.alu_result;
      wb_funct3_d   = rec_q.funct3;
      wb_op_d       = emit_fault ? WNONE : rec_q.wb_op;
      wb_rd_d       = rd_q;
      wb_mem_data_d = emit_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rec_q         <= '0;
      rd_q          <= '0;
      cnt_q         <= '0;
      wb_valid_q    <= 1'b0;
      fault_q       <= 1'b0;
      wb_pc_q       <= '0;
      wb_alu_q      <= '0;
      wb_funct3_q   <= '0;
      wb_op_q       <= '0;
      wb_rd_q       <= '0;
      wb_mem_data_q <= '0;
    end else begin
      state_q       <= state_d;
      rec_q         <= rec_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      wb_valid_q    <= wb_valid_d;
      fault_q       <= fault_d;
      wb_pc_q       <= wb_pc_d;
      wb_alu_q      <= wb_alu_d;
      wb_funct3_q   <= wb_funct3_d;
      wb_op_q       <= wb_op_d;
      wb_rd_q       <= wb_rd_d;
      wb_mem_data_q <= wb_mem_data_d;
    end
  end

  assign ex_ready_out = w_idle;

  // Request outputs are gated so the port reads all-zero outside REQ.
  assign mem_req_out   = (state_q == S_REQ);
  assign mem_we_out    = mem_req_out && (rec_q.mem_op == MSTORE);
  assign mem_addr_out  = mem_req_out ? {rec_q.alu_result[XLEN-1:2], 2'b00} : '0;
  assign mem_wdata_out = mem_req_out ? w_wdata : '0;
  assign mem_be_out    = mem_req_out ? w_be : 4'b0000;

  assign wb_valid_out      = wb_valid_q;
  assign wb_pc_out         = wb_pc_q;
  assign wb_alu_result_out = wb_alu_q;
  assign wb_funct3_out     = wb_funct3_q;
  assign wb_wb_op_out      = wb_op_q;
  assign wb_rd_out         = wb_rd_q;
  assign wb_mem_data_out   = wb_mem_data_q;
  assign mem_fault_out     = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage. Directed scenarios
//               followed by random transactions, each scored against a
//               transaction-level model of latency, lanes and faults.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid_in;
  logic        ex_ready_out;
  logic [31:0] ex_pc_in;
  logic [31:0] ex_alu_result_in;
  logic [31:0] ex_store_data_in;
  logic [2:0]  ex_funct3_in;
  logic [1:0]  ex_mem_op_in;
  logic [2:0]  ex_wb_op_in;
  logic [7:0]  ex_rd_in;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_be_out;
  logic        mem_ready_in;
  logic        mem_rvalid_in;
  logic [31:0] mem_rdata_in;
  logic        wb_valid_out;
  logic [31:0] wb_pc_out;
  logic [31:0] wb_alu_result_out;
  logic [2:0]  wb_funct3_out;
  logic [2:0]  wb_wb_op_out;
  logic [7:0]  wb_rd_out;
  logic [31:0] wb_mem_data_out;
  logic        mem_fault_out;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_stage #(
    .XLEN           (32),
    .RD_WIDTH       (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ex_valid_in       (ex_valid_in),
    .ex_ready_out      (ex_ready_out),
    .ex_pc_in          (ex_pc_in),
    .ex_alu_result_in  (ex_alu_result_in),
    .ex_store_data_in  (ex_store_data_in),
    .ex_funct3_in      (ex_funct3_in),
    .ex_mem_op_in      (ex_mem_op_in),
    .ex_wb_op_in       (ex_wb_op_in),
    .ex_rd_in          (ex_rd_in),
    .mem_req_out       (mem_req_out),
    .mem_we_out        (mem_we_out),
    .mem_addr_out      (mem_addr_out),
    .mem_wdata_out     (mem_wdata_out),
    .mem_be_out        (mem_be_out),
    .mem_ready_in      (mem_ready_in),
    .mem_rvalid_in     (mem_rvalid_in),
    .mem_rdata_in      (mem_rdata_in),
    .wb_valid_out      (wb_valid_out),
    .wb_pc_out         (wb_pc_out),
    .wb_alu_result_out (wb_alu_result_out),
    .wb_funct3_out     (wb_funct3_out),
    .wb_wb_op_out      (wb_wb_op_out),
    .wb_rd_out         (wb_rd_out),
    .wb_mem_data_out   (wb_mem_data_out),
    .mem_fault_out     (mem_fault_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read then.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ex_valid_in   = 1'b0;
    mem_ready_in  = 1'b0;
    mem_rvalid_in = 1'b0;
    mem_rdata_in  = $urandom;
  endtask

  // One transaction presented in the current (idle) cycle.
  // d: REQ cycles before mem_ready_in; r: WAIT cycles before mem_rvalid_in.
  task automatic run_txn(input int op, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] sd, input logic [2:0] f3,
                         input logic [2:0] wbop, input logic [7:0] rd,
                         input int d, input int r, input logic [31:0] rdv);
    bit          is_ld, is_st, is_mem, bad, fault_exp, load_ok;
    int          lat, req_last, kto, k;
    logic [3:0]  be_exp;
    logic [31:0] wd_exp, ld_exp;
    is_ld  = (op == 1);
    is_st  = (op == 2);
    is_mem = is_ld || is_st;
    bad    = is_mem && ((f3 == 3) || (f3 == 6) || (f3 == 7) ||
                        (is_st && (f3 == 4 || f3 == 5)) ||
                        ((f3 == 1 || f3 == 5) && a[0]) ||
                        (f3 == 2 && a[1:0] != 2'b00));
    load_ok  = 1'b0;
    req_last = -1;
    if (!is_mem || bad) begin
      lat = 1; fault_exp = bad;
    end else if (d > TO - 1) begin
      lat = TO + 1; fault_exp = 1'b1; req_last = TO - 1;
    end else if (is_st) begin
      lat = d + 2; fault_exp = 1'b0; req_last = d;
    end else begin
      req_last = d;
      kto = (d + 1 > TO - 1) ? d + 1 : TO - 1;
      if (d + 1 + r <= kto) begin
        lat = d + r + 3; fault_exp = 1'b0; load_ok = 1'b1;
      end else begin
        lat = kto + 2; fault_exp = 1'b1;
      end
    end
    case (f3 % 4)
      0:       begin be_exp = 4'b0001 << a[1:0];              wd_exp = sd[7:0] * 32'h01010101;  end
      1:       begin be_exp = a[1] ? 4'b1100 : 4'b0011;        wd_exp = sd[15:0] * 32'h00010001; end
      default: begin be_exp = 4'b1111;                         wd_exp = sd;                      end
    endcase
    ld_exp = rdv >> (8 * a[1:0]);

    chk("ready_before_accept", ex_ready_out, 1);
    ex_valid_in      = 1'b1;
    ex_pc_in         = pc;
    ex_alu_result_in = a;
    ex_store_data_in = sd;
    ex_funct3_in     = f3;
    ex_mem_op_in     = op[1:0];
    ex_wb_op_in      = wbop;
    ex_rd_in         = rd;
    mem_ready_in     = 1'b0;
    mem_rvalid_in    = 1'($urandom % 2);
    mem_rdata_in     = $urandom;

    for (int c = 1; c <= lat + 1; c++) begin
      tick();
      k = c - 1;
      if (c < lat) begin
        chk("wb_valid_early", wb_valid_out, 0);
        chk("ready_busy", ex_ready_out, 0);
      end
      chk("mem_req", mem_req_out, (is_mem && !bad && k <= req_last) ? 1 : 0);
      if (is_mem && !bad && k <= req_last) begin
        chk("mem_addr", mem_addr_out, a & 32'hFFFF_FFFC);
        chk("mem_we", mem_we_out, is_st ? 1 : 0);
        if (is_st) begin
          chk("mem_be", mem_be_out, be_exp);
          chk("mem_wdata", mem_wdata_out, wd_exp);
        end
      end
      if (c == lat) begin
        chk("wb_valid", wb_valid_out, 1);
        chk("fault", mem_fault_out, fault_exp);
        chk("wb_op", wb_wb_op_out, fault_exp ? 3'd0 : wbop);
        chk("wb_pc", wb_pc_out, pc);
        chk("wb_alu", wb_alu_result_out, a);
        chk("wb_rd", wb_rd_out, rd);
        chk("wb_funct3", wb_funct3_out, f3);
        if (load_ok) chk("wb_mem_data", wb_mem_data_out, ld_exp);
      end
      if (c == lat + 1) begin
        chk("wb_valid_pulse", wb_valid_out, 0);
        chk("fault_pulse", mem_fault_out, 0);
        chk("ready_after", ex_ready_out, 1);
      end else if (c < lat) begin
        // Junk upstream records while stalled must not be taken.
        ex_valid_in      = 1'($urandom % 2);
        ex_pc_in         = $urandom;
        ex_alu_result_in = $urandom;
        ex_mem_op_in     = 2'($urandom_range(0, 2));
        mem_ready_in     = (k == d);
        if (is_ld) mem_rvalid_in = (k == d + 1 + r) || (k <= d && ($urandom % 2 == 1));
        else       mem_rvalid_in = 1'($urandom % 2);
        mem_rdata_in = (is_ld && k == d + 1 + r) ? rdv : $urandom;
      end else begin
        ex_valid_in   = 1'b0;
        mem_ready_in  = 1'b0;
        mem_rvalid_in = 1'($urandom % 2);
        mem_rdata_in  = $urandom;
      end
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          op, d, r;
    logic [2:0]  f3;
    reset            = 1'b1;
    ex_pc_in         = '0;
    ex_alu_result_in = '0;
    ex_store_data_in = '0;
    ex_funct3_in     = '0;
    ex_mem_op_in     = '0;
    ex_wb_op_in      = '0;
    ex_rd_in         = '0;
    set_idle();
    tick();
    tick();
    chk("rst_ready", ex_ready_out, 1);
    chk("rst_wb_valid", wb_valid_out, 0);
    chk("rst_fault", mem_fault_out, 0);
    chk("rst_req", mem_req_out, 0);
    chk("rst_we", mem_we_out, 0);
    chk("rst_addr", mem_addr_out, 0);
    chk("rst_be", mem_be_out, 0);
    chk("rst_wdata", mem_wdata_out, 0);
    chk("rst_wb_pc", wb_pc_out, 0);
    chk("rst_wb_rd", wb_rd_out, 0);
    chk("rst_wb_data", wb_mem_data_out, 0);
    reset = 1'b0;

    // Pass-through, byte store, halfword load with stalls, misaligned word.
    run_txn(0, 32'h0000_0040, 32'h0000_1234, 32'h0,        3'd0, 3'd1, 8'd5,  0,   0, 32'h0);
    run_txn(2, 32'h0000_0044, 32'h0000_0103, 32'h0000_00AB, 3'd0, 3'd1, 8'd0,  0,   0, 32'h0);
    run_txn(1, 32'h0000_0048, 32'h0000_0202, 32'h0,        3'd1, 3'd2, 8'd7,  3,   1, 32'hBEEF_0000);
    run_txn(1, 32'h0000_004C, 32'h0000_0301, 32'h0,        3'd2, 3'd2, 8'd9,  0,   0, 32'h0);
    // Store never accepted: timeout, then a fresh record is accepted.
    run_txn(2, 32'h0000_0050, 32'h0000_0400, 32'h1122_3344, 3'd2, 3'd1, 8'd3,  100, 0, 32'h0);
    run_txn(0, 32'h0000_0054, 32'h0000_5678, 32'h0,        3'd0, 3'd3, 8'd4,  0,   0, 32'h0);
    // Load whose read data never returns before the limit.
    run_txn(1, 32'h0000_0058, 32'h0000_0500, 32'h0,        3'd2, 3'd2, 8'd6,  1,   20, 32'h0);
    // Unsigned-store funct3 faults.
    run_txn(2, 32'h0000_005C, 32'h0000_0600, 32'h0,        3'd4, 3'd1, 8'd8,  0,   0, 32'h0);

    // Reset while waiting for read data; the late rvalid must be dropped.
    chk("rw_ready", ex_ready_out, 1);
    ex_valid_in = 1'b1; ex_mem_op_in = 2'd1; ex_funct3_in = 3'd2;
    ex_alu_result_in = 32'h0000_0300; ex_wb_op_in = 3'd2; ex_rd_in = 8'd2;
    tick();
    chk("rw_req", mem_req_out, 1);
    ex_valid_in = 1'b0; mem_ready_in = 1'b1;
    tick();
    chk("rw_wait_req", mem_req_out, 0);
    chk("rw_wait_busy", ex_ready_out, 0);
    mem_ready_in = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; mem_rvalid_in = 1'b1; mem_rdata_in = 32'hDEAD_BEEF;
    chk("rw_rst_req", mem_req_out, 0);
    chk("rw_rst_ready", ex_ready_out, 1);
    chk("rw_rst_valid", wb_valid_out, 0);
    tick();
    mem_rvalid_in = 1'b0;
    chk("rw_late_valid", wb_valid_out, 0);
    chk("rw_late_fault", mem_fault_out, 0);
    chk("rw_late_req", mem_req_out, 0);
    tick();
    chk("rw_late_valid2", wb_valid_out, 0);
    chk("rw_idle_ready", ex_ready_out, 1);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 2);
      f3 = 3'($urandom_range(0, 7));
      d  = $urandom_range(0, 10);
      r  = $urandom_range(0, 8);
      run_txn(op, $urandom, $urandom, $urandom, f3, 3'($urandom_range(1, 4)),
              8'($urandom), d, r, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
